// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// State encoding and fixed requester slots.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DRAIN,
        DONE
    } state_t;

    localparam int REQ_INPUT  = 0;
    localparam int REQ_READER = 1;
    localparam int REQ_WRITER = 2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Search starts just after the previous owner.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] j;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = IDX_W'((int'(last_owner) + i) % NUM_REQ);
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = j;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter: round-robin burst grants,
// sequential addressing and tagged read-data return.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        beat_ack,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic                      mem_re,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DRN_W = (MEM_RD_LAT > 2) ? $clog2(MEM_RD_LAT) : 1;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      owner_q;
    logic [IDX_W-1:0]      last_q;
    logic [ADDR_W-1:0]     base_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      cnt_q;
    logic                  we_q;
    logic [DRN_W-1:0]      drn_q;
    logic                  last_beat;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic [LEN_W-1:0]      pick_len;

    logic [MEM_RD_LAT-1:0] pv_q;
    logic [IDX_W-1:0]      pt_q [MEM_RD_LAT];

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .last_owner (last_q),
        .onehot     (pick_oh),
        .idx        (pick_idx)
    );

    assign pick_any  = |pick_oh;
    assign pick_len  = req_len[pick_idx*LEN_W +: LEN_W];
    assign last_beat = (cnt_q == len_q - 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Done pulse coincides with the final rvalid of a read burst.
    always_comb begin
        state_d   = state_q;
        gnt       = '0;
        beat_ack  = '0;
        done      = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = (pick_len == '0) ? DONE : BURST;
                end
            end
            BURST: begin
                gnt[owner_q] = 1'b1;
                mem_addr     = base_q + ADDR_W'(cnt_q);
                if (we_q) begin
                    mem_we            = 1'b1;
                    mem_wdata         = req_wdata[owner_q*DATA_W +: DATA_W];
                    beat_ack[owner_q] = 1'b1;
                end else begin
                    mem_re = 1'b1;
                end
                if (last_beat) begin
                    state_d = (we_q || MEM_RD_LAT == 1) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                gnt[owner_q] = 1'b1;
                if (drn_q == DRN_W'(MEM_RD_LAT - 2)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done[owner_q] = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            drn_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        base_q  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        len_q   <= pick_len;
                        we_q    <= req_we[pick_idx];
                        cnt_q   <= '0;
                        drn_q   <= '0;
                    end
                end
                BURST:   cnt_q  <= cnt_q + 1'b1;
                DRAIN:   drn_q  <= drn_q + 1'b1;
                DONE:    last_q <= owner_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv_q <= '0;
            for (int i = 0; i < MEM_RD_LAT; i++) begin
                pt_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= mem_re;
            pt_q[0] <= owner_q;
            for (int i = 1; i < MEM_RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pt_q[i] <= pt_q[i-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (pv_q[MEM_RD_LAT-1]) begin
            rvalid[pt_q[MEM_RD_LAT-1]] = 1'b1;
            rdata                      = mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner
// sequences and random traffic against a burst-schedule model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 1;
    localparam int NC  = 8192;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  req_we;
    logic [47:0] req_addr;
    logic [23:0] req_len;
    logic [95:0] req_wdata;
    logic [2:0]  gnt;
    logic [2:0]  beat_ack;
    logic [2:0]  rvalid;
    logic [31:0] rdata;
    logic [2:0]  done;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .NUM_REQ    (3),
        .ADDR_W     (16),
        .DATA_W     (32),
        .LEN_W      (8),
        .MEM_RD_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .beat_ack  (beat_ack),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] h(logic [15:0] a);
        return {a ^ 16'hA5C3, ~a} + 32'h0101_0101;
    endfunction

    // Memory: read data is a fixed function of the address, LAT cycles later.
    logic [15:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= mem_addr;
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign mem_rdata = h(mp[LAT-1]);

    typedef struct packed {
        logic [2:0]  gnt;
        logic [2:0]  ack;
        logic [2:0]  rv;
        logic [2:0]  dn;
        logic [15:0] addr;
        logic [15:0] raddr;
        logic        we;
        logic        re;
        logic [1:0]  own;
    } exp_t;

    exp_t ex [NC];
    int   cyc;
    int   idle;
    int   last;
    int   total;
    int   bad;

    int          obs_beats;
    int          obs_rv;
    logic [15:0] obs_first;
    logic [15:0] obs_last;
    bit          obs_done_seen;
    int          obs_done_cyc;
    int          obs_done_who;

    task automatic chk(string nm, longint act, longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    // Burst schedule model: a winning request at cycle c occupies the port
    // for beats c+1..c+len, read data lands LAT later, then one done cycle.
    task automatic model(int c);
        int          w;
        int          best;
        int          rk;
        int          n;
        int          d;
        int          t;
        bit          wr;
        logic [15:0] b;
        logic [15:0] a;
        if (!rst) begin
            for (int k = c; k < c + 300; k++) if (k < NC) ex[k] = '0;
            idle = c + 1;
            last = 2;
        end else if (c == idle) begin
            w    = -1;
            best = 99;
            for (int j = 0; j < 3; j++) begin
                rk = (j - last - 1 + 6) % 3;
                if (req[j] && rk < best) begin
                    best = rk;
                    w    = j;
                end
            end
            if (w < 0) begin
                idle = c + 1;
            end else begin
                n  = int'(req_len[w*8 +: 8]);
                wr = req_we[w];
                b  = req_addr[w*16 +: 16];
                d  = (n == 0) ? c + 1 : (wr ? c + 1 + n : c + n + LAT);
                for (int k = c + 1; k < d; k++) ex[k].gnt[w] = 1'b1;
                for (int k = 0; k < n; k++) begin
                    t = c + 1 + k;
                    a = b + 16'(k);
                    ex[t].addr = a;
                    ex[t].own  = 2'(w);
                    if (wr) begin
                        ex[t].we     = 1'b1;
                        ex[t].ack[w] = 1'b1;
                    end else begin
                        ex[t].re           = 1'b1;
                        ex[t+LAT].rv[w]    = 1'b1;
                        ex[t+LAT].raddr    = a;
                    end
                end
                ex[d].dn[w] = 1'b1;
                idle = d + 1;
                last = w;
            end
        end
    endtask

    task automatic cycle_check(int c);
        exp_t        e;
        logic [31:0] ewd;
        logic [31:0] erd;
        e   = ex[c];
        ewd = e.we ? req_wdata[e.own*32 +: 32] : 32'h0;
        erd = (|e.rv) ? h(e.raddr) : 32'h0;
        total++;
        if (gnt !== e.gnt || beat_ack !== e.ack || rvalid !== e.rv ||
            done !== e.dn || mem_addr !== e.addr || mem_we !== e.we ||
            mem_re !== e.re || mem_wdata !== ewd || rdata !== erd) begin
            bad++;
            $display("FAIL cycle %0d: got g=%b k=%b v=%b d=%b a=%h w=%b r=%b wd=%h rd=%h want g=%b k=%b v=%b d=%b a=%h w=%b r=%b wd=%h rd=%h",
                c, gnt, beat_ack, rvalid, done, mem_addr, mem_we, mem_re,
                mem_wdata, rdata, e.gnt, e.ack, e.rv, e.dn, e.addr, e.we,
                e.re, ewd, erd);
        end
        if (mem_we === 1'b1 || mem_re === 1'b1) begin
            if (obs_beats == 0) obs_first = mem_addr;
            obs_last = mem_addr;
            obs_beats++;
        end
        if (|rvalid) obs_rv++;
        for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
                obs_done_seen = 1'b1;
                obs_done_cyc  = c;
                obs_done_who  = i;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model(cyc);
        cycle_check(cyc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_obs();
        obs_beats     = 0;
        obs_rv        = 0;
        obs_first     = '0;
        obs_last      = '0;
        obs_done_seen = 1'b0;
        obs_done_cyc  = -1;
        obs_done_who  = -1;
    endtask

    task automatic wait_done(output int who);
        int g;
        g = 0;
        obs_done_seen = 1'b0;
        while (!obs_done_seen && g < 80) begin
            step();
            g++;
        end
        who = obs_done_seen ? obs_done_who : -1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    typedef struct {
        int          id;
        bit          we;
        logic [15:0] addr;
        int          len;
        logic [15:0] first;
        logic [15:0] lst;
        int          beats;
        int          rvs;
        int          doff;
    } vec_t;

    vec_t vt [7];

    initial begin
        int who;
        int g;
        int t0;
        int ord [4];
        total = 0;
        bad   = 0;
        cyc   = 0;
        idle  = 0;
        last  = 2;
        for (int k = 0; k < NC; k++) ex[k] = '0;
        clear_obs();
        rst       = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;

        vt[0] = '{REQ_READER, 1'b0, 16'h0100, 4,  16'h0100, 16'h0103, 4,  4,  4 + LAT};
        vt[1] = '{REQ_WRITER, 1'b1, 16'h0200, 3,  16'h0200, 16'h0202, 3,  0,  4};
        vt[2] = '{REQ_INPUT,  1'b0, 16'hFFFE, 4,  16'hFFFE, 16'h0001, 4,  4,  4 + LAT};
        vt[3] = '{REQ_INPUT,  1'b1, 16'h0000, 0,  16'h0000, 16'h0000, 0,  0,  1};
        vt[4] = '{REQ_WRITER, 1'b0, 16'h1234, 1,  16'h1234, 16'h1234, 1,  1,  1 + LAT};
        vt[5] = '{REQ_READER, 1'b1, 16'hFFFF, 2,  16'hFFFF, 16'h0000, 2,  0,  3};
        vt[6] = '{REQ_INPUT,  1'b0, 16'h7FF0, 16, 16'h7FF0, 16'h7FFF, 16, 16, 16 + LAT};

        #1;
        step();
        chk("reset_outputs", {gnt, beat_ack, rvalid, done, mem_we, mem_re, mem_addr}, 0);
        step();
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            g = 0;
            while (cyc != idle && g < 100) begin
                step();
                g++;
            end
            clear_obs();
            req                       = 3'b001 << vt[i].id;
            req_we[vt[i].id]          = vt[i].we;
            req_addr[vt[i].id*16 +: 16] = vt[i].addr;
            req_len[vt[i].id*8 +: 8]  = 8'(vt[i].len);
            req_wdata                 = {$urandom, $urandom, $urandom};
            t0 = cyc;
            step();
            req = '0;
            g = 0;
            while (!obs_done_seen && g < 60) begin
                req_wdata = {$urandom, $urandom, $urandom};
                step();
                g++;
            end
            chk($sformatf("vec%0d_done_off", i), obs_done_seen ? obs_done_cyc - t0 : -1, vt[i].doff);
            chk($sformatf("vec%0d_done_who", i), obs_done_who, vt[i].id);
            chk($sformatf("vec%0d_beats", i), obs_beats, vt[i].beats);
            chk($sformatf("vec%0d_first", i), obs_first, vt[i].first);
            chk($sformatf("vec%0d_last", i), obs_last, vt[i].lst);
            chk($sformatf("vec%0d_rvalids", i), obs_rv, vt[i].rvs);
        end

        do_reset();
        req      = 3'b111;
        req_we   = 3'b000;
        req_addr = {16'h3000, 16'h2000, 16'h1000};
        req_len  = {8'd2, 8'd2, 8'd2};
        ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 0;
        for (int i = 0; i < 4; i++) begin
            wait_done(who);
            chk($sformatf("order%0d", i), who, ord[i]);
        end
        req = '0;

        do_reset();
        clear_obs();
        req                = 3'b010;
        req_we             = 3'b000;
        req_addr[16 +: 16] = 16'h0040;
        req_len[8 +: 8]    = 8'd8;
        step();
        req = '0;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_re", mem_re, 0);
        chk("midrst_addr", mem_addr, 0);
        step();
        step();
        rst = 1'b1;
        obs_rv = 0;
        repeat (6) step();
        chk("midrst_stale_rv", obs_rv, 0);
        req     = 3'b111;
        req_len = {8'd1, 8'd1, 8'd1};
        wait_done(who);
        chk("midrst_first_gnt", who, REQ_INPUT);
        req = '0;

        do_reset();
        clear_obs();
        req          = 3'b001;
        req_we       = 3'b001;
        req_len[7:0] = 8'd0;
        wait_done(who);
        chk("len0_done", who, REQ_INPUT);
        chk("len0_beats", obs_beats, 0);
        req     = 3'b111;
        req_len = {8'd1, 8'd1, 8'd1};
        wait_done(who);
        chk("len0_next_gnt", who, REQ_READER);
        req = '0;

        repeat (2000) begin
            rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            req = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            req_we = 3'($urandom_range(0, 7));
            for (int j = 0; j < 3; j++) begin
                req_addr[j*16 +: 16] = ($urandom_range(0, 3) == 0) ?
                    16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
                req_len[j*8 +: 8] = 8'($urandom_range(0, 6));
            end
            req_wdata = {$urandom, $urandom, $urandom};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
